// File: rtl/add8_accumulator.sv
// Burst accumulator: sums BURST operands through a ripple adder, then presents the
// total with sticky carry/overflow flags over a valid/ready handshake.
module add8_accumulator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 4,
  parameter int unsigned CNTW  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc_out,
  output logic             carry_out,
  output logic             ovf_out,
  output logic [CNTW-1:0]  count
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_sum;
  logic             add_c;
  logic             add_ovf;
  logic             accept;
  logic             last;
  logic             flag_c;
  logic             flag_v;

  // Ripple adder; a burst's first operand is added to zero so flags start fresh.
  always_comb begin
    add_a   = (state == ACCUM) ? acc_out : '0;
    add_sum = '0;
    add_c   = in_ci;
    for (int i = 0; i < int'(WIDTH); i++) begin
      add_sum[i] = add_a[i] ^ in_data[i] ^ add_c;
      add_c      = (add_a[i] & in_data[i]) | (add_c & (add_a[i] ^ in_data[i]));
    end
    add_ovf = (add_a[WIDTH-1] == in_data[WIDTH-1]) && (add_sum[WIDTH-1] != in_data[WIDTH-1]);
    accept  = in_valid && in_ready;
    last    = (count == CNTW'(BURST - 1));
    flag_c  = ((state == ACCUM) && carry_out) || add_c;
    flag_v  = ((state == ACCUM) && ovf_out) || add_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      acc_out   <= '0;
      carry_out <= 1'b0;
      ovf_out   <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_out   <= add_sum;
            carry_out <= flag_c;
            ovf_out   <= flag_v;
            count     <= count + CNTW'(1);
            if (last) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc_out   <= '0;
            carry_out <= 1'b0;
            ovf_out   <= 1'b0;
            count     <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
